// File: rtl/cordic_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cordic_scheduler_if                                                  |
// | Request/response handshakes and CORDIC core bus of the scheduler.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface cordic_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_angle;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [16*NREQ-1:0]   resp_cos;
  logic [16*NREQ-1:0]   resp_sin;
  logic [15:0]          cordic_xstart;
  logic [15:0]          cordic_ystart;
  logic [31:0]          cordic_angle;
  logic [15:0]          cordic_xout;
  logic [15:0]          cordic_yout;
  logic                 busy;

  modport slave (
    input  req_valid, req_angle, resp_ready, cordic_xout, cordic_yout,
    output req_ready, resp_valid, resp_cos, resp_sin,
           cordic_xstart, cordic_ystart, cordic_angle, busy
  );

  modport master (
    output req_valid, req_angle, resp_ready, cordic_xout, cordic_yout,
    input  req_ready, resp_valid, resp_cos, resp_sin,
           cordic_xstart, cordic_ystart, cordic_angle, busy
  );
endinterface
`default_nettype wire

// File: rtl/cordic_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cordic_scheduler                                                     |
// | Round-robin sharing of one pipelined CORDIC core among requesters.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cordic_scheduler #(
  parameter int                 NREQ   = 4,
  parameter int                 LAT    = 15,
  parameter logic signed [15:0] X_INIT = 16'sh7FFF
) (
  input logic               clock,
  input logic               reset,
  cordic_scheduler_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW  = IDW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q [NREQ];
  logic [1:0]            state_d [NREQ];
  logic [IDW-1:0]        rr_q, rr_d;
  logic [LAT:0]          tag_vld_q;
  logic [IDW-1:0]        tag_id_q [LAT+1];
  logic [NREQ-1:0][15:0] cos_q, sin_q;
  logic [NREQ-1:0][31:0] angle_w;
  logic [NREQ-1:0]       elig_w;
  logic                  grant_vld_w;
  logic [IDW-1:0]        grant_id_w;
  logic                  cap_vld_w;
  logic [IDW-1:0]        cap_id_w;

  assign angle_w   = bus.req_angle;
  assign cap_vld_w = tag_vld_q[LAT];
  assign cap_id_w  = tag_id_q[LAT];

  always_comb begin
    elig_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_w[i] = bus.req_valid[i] && (state_q[i] == ST_IDLE);
    end
  end

  // First eligible requester scanning upward from rr_q, wrapping modulo NREQ.
  always_comb begin
    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;
    grant_vld_w = 1'b0;
    grant_id_w  = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + SW'(k);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!grant_vld_w && elig_w[idx]) begin
        grant_vld_w = 1'b1;
        grant_id_w  = idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        state_q[i] <= ST_IDLE;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        state_q[i] <= state_d[i];
      end
      rr_q <= rr_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (grant_vld_w && (grant_id_w == IDW'(i))) state_d[i] = ST_BUSY;
        ST_BUSY: if (cap_vld_w && (cap_id_w == IDW'(i)))     state_d[i] = ST_DONE;
        ST_DONE: if (bus.resp_ready[i])                      state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
    end
    rr_d = rr_q;
    if (grant_vld_w) begin
      rr_d = (grant_id_w == IDW'(NREQ - 1)) ? '0 : grant_id_w + 1'b1;
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.busy       = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i]  = grant_vld_w && (grant_id_w == IDW'(i));
      bus.resp_valid[i] = (state_q[i] == ST_DONE);
      if (state_q[i] != ST_IDLE) begin
        bus.busy = 1'b1;
      end
    end
    bus.cordic_xstart = grant_vld_w ? X_INIT : '0;
    bus.cordic_ystart = '0;
    bus.cordic_angle  = grant_vld_w ? angle_w[grant_id_w] : '0;
  end

  // Tag pipeline is one stage longer than the core so capture lands on edge LAT+1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_vld_q   <= {tag_vld_q[LAT-1:0], grant_vld_w};
      tag_id_q[0] <= grant_id_w;
      for (int s = 1; s <= LAT; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (cap_vld_w) begin
      cos_q[cap_id_w] <= bus.cordic_xout;
      sin_q[cap_id_w] <= bus.cordic_yout;
    end
  end

  assign bus.resp_cos = cos_q;
  assign bus.resp_sin = sin_q;
endmodule
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cordic_scheduler                                                  |
// | Directed bench with an ideal CORDIC core model and result scoreboard.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cordic_scheduler;
  localparam int          NREQ   = 4;
  localparam int          LAT    = 15;
  localparam logic [15:0] X_INIT = 16'h7FFF;
  localparam real         GAIN   = 0.97781;

  typedef struct {
    int          id;
    logic [15:0] c;
    logic [15:0] s;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0;
  int   g, last_g, n_g;
  exp_t sb[$];
  logic [NREQ-1:0] prev_rv = '0;
  logic [15:0] last_c [NREQ];
  logic [15:0] last_s [NREQ];
  logic [15:0] cx [LAT+1];
  logic [15:0] cy [LAT+1];

  cordic_scheduler_if #(.NREQ(NREQ)) bus ();

  cordic_scheduler #(
    .NREQ   (NREQ),
    .LAT    (LAT),
    .X_INIT (16'sh7FFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [15:0] fcos(input logic [15:0] xs, input logic [15:0] ys, input logic [31:0] a);
    real th = real'(a) * 6.283185307179586 / 4294967296.0;
    return 16'(rnd(GAIN * (real'($signed(xs)) * $cos(th) - real'($signed(ys)) * $sin(th))));
  endfunction

  function automatic logic [15:0] fsin(input logic [15:0] xs, input logic [15:0] ys, input logic [31:0] a);
    real th = real'(a) * 6.283185307179586 / 4294967296.0;
    return 16'(rnd(GAIN * (real'($signed(xs)) * $sin(th) + real'($signed(ys)) * $cos(th))));
  endfunction

  // Ideal core: result appears LAT edges after the edge that sampled the inputs.
  always @(posedge clock) begin
    cx[0] <= fcos(bus.cordic_xstart, bus.cordic_ystart, bus.cordic_angle);
    cy[0] <= fsin(bus.cordic_xstart, bus.cordic_ystart, bus.cordic_angle);
    for (int s = 1; s <= LAT; s++) begin
      cx[s] <= cx[s-1];
      cy[s] <= cy[s-1];
    end
  end
  assign bus.cordic_xout = cx[LAT];
  assign bus.cordic_yout = cy[LAT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [15:0] obs, input int exp);
    int o;
    o = $signed(obs);
    n_chk++;
    assert ((o >= exp - 64) && (o <= exp + 64)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +-64", tag, o, exp);
    end
  endtask

  task automatic set_ang(input int i, input logic [31:0] a);
    bus.req_angle[32*i +: 32] = a;
  endtask

  // One clock: optional grant check, scoreboard push on issue, edge, response pop.
  task automatic tick(input bit do_chk, input logic [NREQ-1:0] exp_rdy);
    exp_t e;
    #1;
    if (do_chk) chk("req_ready", bus.req_ready, exp_rdy);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i] && !reset) begin
        sb.push_back('{i,
                       fcos(X_INIT, 16'h0, bus.req_angle[32*i +: 32]),
                       fsin(X_INIT, 16'h0, bus.req_angle[32*i +: 32]),
                       cyc + 1 + LAT + 1});
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.resp_valid[i] && !prev_rv[i]) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", bus.resp_valid[i], 1'b0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", i, e.id);
          chk("resp_cycle", cyc, e.due);
          chk("resp_cos", bus.resp_cos[16*i +: 16], e.c);
          chk("resp_sin", bus.resp_sin[16*i +: 16], e.s);
          last_c[i] = e.c;
          last_s[i] = e.s;
        end
      end
    end
    prev_rv = bus.resp_valid;
  endtask

  task automatic wait_resp(input int i, input int bound);
    int n;
    n = 0;
    while (!bus.resp_valid[i] && n < bound) begin
      tick(1'b0, '0);
      n++;
    end
    chk("wait_resp", bus.resp_valid[i], 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    tick(1'b0, '0);
    tick(1'b0, '0);
    reset = 1'b0;
    sb.delete();
    prev_rv = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.req_angle  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", bus.resp_valid, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_resp_cos", bus.resp_cos, '0);
    chk("rst_resp_sin", bus.resp_sin, '0);
    reset = 1'b0;

    // Single request, angle 0
    set_ang(0, 32'h0000_0000);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_xstart", bus.cordic_xstart, X_INIT);
    chk("t1_ystart", bus.cordic_ystart, 16'h0);
    tick(1'b1, 4'b0001);
    t0 = cyc;
    bus.req_valid = '0;
    chk("t1_xstart_idle", bus.cordic_xstart, 16'h0);
    wait_resp(0, 40);
    chk("t1_latency", cyc - t0, LAT + 1);
    chk_near("t1_cos", bus.resp_cos[15:0], 32040);
    chk_near("t1_sin", bus.resp_sin[15:0], 0);
    bus.resp_ready = 4'b0001;
    tick(1'b0, '0);
    bus.resp_ready = '0;
    chk("t1_valid_drop", bus.resp_valid[0], 1'b0);
    chk("t1_busy_low", bus.busy, 1'b0);

    // 90 degrees on requester 2 with a delayed consumer
    set_ang(2, 32'h4000_0000);
    bus.req_valid = 4'b0100;
    #1;
    chk("t2_angle", bus.cordic_angle, 32'h4000_0000);
    tick(1'b1, 4'b0100);
    bus.req_valid = '0;
    wait_resp(2, 40);
    chk_near("t2_sin", bus.resp_sin[47:32], 32040);
    chk_near("t2_cos", bus.resp_cos[47:32], 0);
    repeat (10) begin
      tick(1'b0, '0);
      chk("t2_hold_valid", bus.resp_valid[2], 1'b1);
      chk("t2_hold_cos", bus.resp_cos[47:32], last_c[2]);
      chk("t2_hold_sin", bus.resp_sin[47:32], last_s[2]);
    end
    bus.resp_ready = 4'b0100;
    tick(1'b0, '0);
    bus.resp_ready = '0;
    chk("t2_valid_drop", bus.resp_valid[2], 1'b0);

    // All four requesting from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ang(i, 32'h1234_5678 * (i + 1));
    bus.req_valid = 4'b1111;
    tick(1'b1, 4'b0001);
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b0100);
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b0000);
    bus.req_valid = '0;
    for (int n = 0; n < 30 && sb.size() != 0; n++) tick(1'b0, '0);
    chk("t3_drained", sb.size(), 0);
    bus.resp_ready = 4'b1111;
    tick(1'b0, '0);
    bus.resp_ready = '0;
    chk("t3_busy_low", bus.busy, 1'b0);

    // Requester 1 holds its result while 0 and 3 keep requesting
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ang(i, 32'h0800_0000 * (i + 3));
    bus.resp_ready = 4'b1001;
    bus.req_valid  = 4'b0010;
    tick(1'b1, 4'b0010);
    bus.req_valid = 4'b1011;
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b0001);
    last_g = 0;
    n_g = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      chk("t4_no_grant_1", bus.req_ready[1], 1'b0);
      if (bus.req_ready != '0) begin
        g = bus.req_ready[3] ? 3 : 0;
        chk("t4_onehot", $onehot(bus.req_ready), 1'b1);
        chk("t4_alternate", (g != last_g), 1'b1);
        last_g = g;
        n_g++;
      end
      tick(1'b0, '0);
    end
    chk("t4_grant_count", (n_g >= 4), 1'b1);
    bus.req_valid = '0;
    repeat (20) tick(1'b0, '0);
    bus.req_valid  = 4'b0010;
    bus.resp_ready = 4'b0010;
    tick(1'b1, 4'b0000);
    bus.resp_ready = '0;
    tick(1'b1, 4'b0010);
    bus.req_valid  = '0;
    bus.resp_ready = 4'b1111;
    wait_resp(1, 40);
    tick(1'b0, '0);
    bus.resp_ready = '0;
    chk("t4_busy_low", bus.busy, 1'b0);

    // +45 / -45 degrees back to back
    do_reset();
    set_ang(0, 32'h2000_0000);
    set_ang(1, 32'hE000_0000);
    bus.req_valid = 4'b0011;
    tick(1'b1, 4'b0001);
    bus.req_valid = 4'b0010;
    tick(1'b1, 4'b0010);
    bus.req_valid = '0;
    wait_resp(1, 40);
    chk("t5_both_valid", bus.resp_valid[0], 1'b1);
    chk_near("t5_sin0", bus.resp_sin[15:0], 22656);
    chk_near("t5_sin1", bus.resp_sin[31:16], -22656);
    chk_near("t5_cos0", bus.resp_cos[15:0], 22656);
    chk_near("t5_cos1", bus.resp_cos[31:16], 22656);
    bus.resp_ready = 4'b0011;
    tick(1'b0, '0);
    bus.resp_ready = '0;

    // Reset while three requests are in flight
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ang(i, 32'h1555_5555 * (i + 1));
    bus.req_valid = 4'b0111;
    tick(1'b1, 4'b0001);
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b0100);
    bus.req_valid = '0;
    repeat (5) tick(1'b0, '0);
    chk("t6_busy_before", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", bus.resp_valid, '0);
    chk("t6_async_busy", bus.busy, 1'b0);
    sb.delete();
    tick(1'b0, '0);
    tick(1'b0, '0);
    reset = 1'b0;
    for (int n = 0; n < LAT + 5; n++) begin
      tick(1'b0, '0);
      chk("t6_no_resp", bus.resp_valid, '0);
    end
    chk("t6_busy_after", bus.busy, 1'b0);
    bus.req_valid = 4'b1100;
    tick(1'b1, 4'b0100);
    bus.req_valid  = '0;
    bus.resp_ready = 4'b1111;
    wait_resp(2, 40);
    tick(1'b0, '0);
    bus.resp_ready = '0;
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cordic_scheduler.md
Name: cordic_scheduler

Overview:
Shares one pipelined CORDIC sin/cos core among NREQ requesters. Each requester submits an angle over a valid/ready handshake. A round-robin arbiter issues at most one request per cycle into the core. A tag pipeline matched to the core latency routes each result back to the requester that issued it, where it is held until that requester accepts it.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 15, clock edges from the issue edge until cordic_xout/cordic_yout hold the result for that issue
X_INIT, 16'sh7FFF, value driven on cordic_xstart for every issue (unit vector magnitude)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  NREQ  request present, one bit per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_angle  in  32*NREQ  angle per requester, slice i = [32i+31:32i]; 2^32 = 360 degrees
resp_valid  out  NREQ  result held for requester i
resp_ready  in  NREQ  requester i consumes result
resp_cos  out  16*NREQ  cosine result per requester, signed, slice i = [16i+15:16i]
resp_sin  out  16*NREQ  sine result per requester, signed, same slicing
cordic_xstart  out  16  to core; X_INIT when issuing, 0 otherwise
cordic_ystart  out  16  to core; always 0
cordic_angle  out  32  to core; granted angle when issuing, 0 otherwise
cordic_xout  in  16  from core
cordic_yout  in  16  from core
busy  out  1  high while any requester is in BUSY or DONE

Behaviour:
- Per-requester state: IDLE, BUSY (issued, result in flight), DONE (result held).
- Reset values: all states IDLE, tag pipeline all invalid, RR pointer 0, resp_valid=0, resp_cos/resp_sin=0, busy=0.
- Eligible(i) = req_valid[i] && state[i]==IDLE.
- Grant: the first eligible index, scanning from rr_ptr upward and wrapping modulo NREQ. Grant is combinational.
- req_ready[i] = 1 only for the granted i. Issue occurs on the edge where req_valid[i] && req_ready[i].
- On issue: rr_ptr <= grant+1 (mod NREQ); state[grant] <= BUSY.
- On issue, the core inputs are driven combinationally in the issue cycle, so the core samples them on the issue edge.
- Tag pipeline: LAT+1 stages of {valid, id[clog2(NREQ)-1:0]}. Stage 0 is loaded on the issue edge with {1, grant}, or {0, x} when there is no issue. It shifts every cycle.
- Capture: when the last stage is valid with id k, on that edge resp_cos[k] <= cordic_xout, resp_sin[k] <= cordic_yout, state[k] <= DONE, resp_valid[k] <= 1. This is edge LAT+1 after issue.
- Latency: resp_valid rises exactly LAT+1 cycles after the issue cycle. Throughput is one issue per cycle across requesters, but at most one outstanding request per requester.
- Response: while DONE, resp_valid[i]=1 and the data is stable. On an edge with resp_ready[i]=1, state goes to IDLE and resp_valid drops.
- A requester can be granted again no earlier than the cycle after its response handshake.
- Simultaneous events:
  - Capture for k and response handshake for j≠k on the same edge are independent.
  - Capture and issue on the same edge are independent.
  - Capture for k while k is DONE cannot occur, because there is at most one request outstanding per requester.
- The CORDIC gain is absorbed by the core. Outputs are passed through unmodified, with no rescaling and no saturation.
- Reset mid-operation: in-flight tags are discarded, all held results are cleared, and grants restart from requester 0. Core outputs arriving after reset are ignored because their tags are invalid.
- busy = OR of (state != IDLE). It is registered-state derived, with no combinational dependence on the req inputs.

Test Plan:
- Single request, requester 0, angle 0x00000000 -> req_ready[0] high same cycle; resp_valid[0] exactly 16 cycles later; resp_cos ≈ 32040 (±64), resp_sin ≈ 0 (±64).
- Requester 2, angle 0x40000000 (90°), resp_ready held low 10 cycles -> resp_sin ≈ 32040, resp_cos ≈ 0 (±64); data stable while DONE; resp_valid drops the edge after resp_ready=1.
- All four request continuously from reset -> issues in order 0,1,2,3 on consecutive cycles; results on cycles 16,17,18,19, each routed to its own requester.
- Requester 1 holds its result; requesters 0 and 3 keep requesting -> no further grant to 1 until its handshake; 0 and 3 alternate each cycle they are eligible.
- Issue 0x20000000 (45°) and 0xE0000000 (-45°) back-to-back -> sin ≈ +22656 / -22656 and cos ≈ 22656 both (±64), delivered on consecutive cycles.
- Assert reset 5 cycles after three issues -> resp_valid stays 0 for all requesters through LAT+5 cycles; busy=0; the next request is granted to the lowest eligible index.
